// File: rtl/d_flip_flop.sv
// Parameterised D register / delay chain with enable, sync clear and change flag.
// Define D_FLIP_FLOP_HOLD_CNT_EN to add the saturating hold_cnt output.
module d_flip_flop #(
  parameter int          WIDTH   = 1,
  parameter int          STAGES  = 1,
  parameter logic [63:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sclr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
`ifdef D_FLIP_FLOP_HOLD_CNT_EN
  output logic [7:0]       hold_cnt,
`endif
  output logic             changed
);

  localparam logic [WIDTH-1:0] RV = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] stage [STAGES];
  logic [WIDTH-1:0] nxt   [STAGES];
  logic             q_chg;

  always_comb begin
    nxt = stage;
    if (sclr) begin
      for (int i = 0; i < STAGES; i++)
        nxt[i] = RV;
    end else if (en) begin
      nxt[0] = d;
      for (int i = 1; i < STAGES; i++)
        nxt[i] = stage[i-1];
    end
  end

  assign q_chg = (nxt[STAGES-1] != stage[STAGES-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++)
        stage[i] <= RV;
      changed <= 1'b0;
    end else begin
      stage   <= nxt;
      changed <= q_chg;
    end
  end

`ifdef D_FLIP_FLOP_HOLD_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hold_cnt <= 8'h00;
    else if (q_chg)
      hold_cnt <= 8'h00;
    else if (hold_cnt != 8'hFF)
      hold_cnt <= hold_cnt + 8'h01;
  end
`endif

  assign q   = stage[STAGES-1];
  assign q_n = ~q;

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop: single stage, 3-stage chain and
// a 4-bit 2-stage instance with a truncated reset value.
module tb_d_flip_flop;

  logic       clk = 1'b0;
  logic       rst, en, sclr, d;
  logic [3:0] d4;
  logic       q1, qn1, ch1;
  logic       q3, qn3, ch3;
  logic [3:0] q4, qn4;
  logic       ch4;
  int         pass  = 0;
  int         total = 0;
`ifdef D_FLIP_FLOP_HOLD_CNT_EN
  logic [7:0] hc1, hc3, hc4;
`endif

  always #5 clk = ~clk;

  d_flip_flop #(.WIDTH(1), .STAGES(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .sclr(sclr), .d(d),
    .q(q1), .q_n(qn1),
`ifdef D_FLIP_FLOP_HOLD_CNT_EN
    .hold_cnt(hc1),
`endif
    .changed(ch1));

  d_flip_flop #(.WIDTH(1), .STAGES(3)) u3 (
    .clk(clk), .rst(rst), .en(en), .sclr(sclr), .d(d),
    .q(q3), .q_n(qn3),
`ifdef D_FLIP_FLOP_HOLD_CNT_EN
    .hold_cnt(hc3),
`endif
    .changed(ch3));

  d_flip_flop #(.WIDTH(4), .STAGES(2), .RST_VAL(64'h1A)) u4 (
    .clk(clk), .rst(rst), .en(en), .sclr(sclr), .d(d4),
    .q(q4), .q_n(qn4),
`ifdef D_FLIP_FLOP_HOLD_CNT_EN
    .hold_cnt(hc4),
`endif
    .changed(ch4));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sclr = 1'b0; d = 1'b1; d4 = 4'h3;
    #1;
    chk("rst_q", q1, 0);
    chk("rst_qn", qn1, 1);
    chk("rst_ch", ch1, 0);
    chk("rst_q4_trunc", q4, 4'hA);
    chk("rst_qn4", qn4, 4'h5);
`ifdef D_FLIP_FLOP_HOLD_CNT_EN
    chk("rst_hc", hc1, 0);
`endif
    @(negedge clk);
    chk("rst_held", q1, 0);
    rst = 1'b0; en = 1'b1; d = 1'b1;
    tick();
    chk("tog1_q", q1, 1);
    chk("tog1_ch", ch1, 1);
    chk("q4_lat1", q4, 4'hA);
    chk("q4_ch1", ch4, 0);
    d = 1'b0;
    tick();
    chk("tog2_q", q1, 0);
    chk("tog2_ch", ch1, 1);
    chk("q4_lat2", q4, 4'h3);
    chk("q4_ch2", ch4, 1);
    d = 1'b1;
    tick();
    chk("tog3_q", q1, 1);
    chk("tog3_ch", ch1, 1);
    d = 1'b0;
    tick();
    chk("tog4_q", q1, 0);
    chk("tog4_ch", ch1, 1);
    d = 1'b1;
    tick();
    chk("set_q", q1, 1);
    chk("set_qn", qn1, 0);
    en = 1'b0; d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_q", q1, 1);
      chk("hold_ch", ch1, 0);
    end
`ifdef D_FLIP_FLOP_HOLD_CNT_EN
    chk("hold_cnt3", hc1, 3);
`endif
    en = 1'b1; d = 1'b0;
    #2;
    chk("no_comb_path", q1, 1);
    d = 1'b1; sclr = 1'b1;
    tick();
    chk("sclr_q", q1, 0);
    chk("sclr_ch", ch1, 1);
    chk("sclr_q4", q4, 4'hA);
`ifdef D_FLIP_FLOP_HOLD_CNT_EN
    chk("sclr_hc", hc1, 0);
`endif
    tick();
    chk("sclr2_q", q1, 0);
    chk("sclr2_ch", ch1, 0);
    sclr = 1'b0;
    tick();
    chk("refill_q", q1, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_q", q1, 0);
    chk("mid_rst_qn", qn1, 1);
    chk("mid_rst_ch", ch1, 0);
    chk("mid_rst_q4", q4, 4'hA);
    @(negedge clk);
    #1;
    rst = 1'b0; en = 1'b1; d = 1'b1;
    tick();
    chk("chain_e1", q3, 0);
    chk("chain_e1_q1", q1, 1);
    d = 1'b0;
    tick();
    chk("chain_e2", q3, 0);
    tick();
    chk("chain_e3", q3, 1);
    chk("chain_e3_ch", ch3, 1);
    chk("chain_e3_qn", qn3, 0);
    tick();
    chk("chain_e4", q3, 0);
    chk("chain_e4_ch", ch3, 1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
